tero_pair_seq: RTL

// - Decodes a challenge into a TERO group pair (i,j) and streams every TERO index of both groups over a valid/ready port.
// - Sits between the challenge register and the TERO enable/frequency-counter datapath.
// - Parametrised successor of the fixed 16-group/10-bank/8-lane sequencer; adds handshake, last flag, abort and an invalid-challenge error.

---
 rtl/tero_seq_pkg.sv | 17 +
 rtl/tero_pair_decode.sv | 33 +++
 rtl/tero_pair_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tero_seq_pkg.sv
// Shared types and defaults for the TERO pair sequencer.
package tero_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam int unsigned GRP_W_DEF  = 4;
  localparam int unsigned N_BANK_DEF = 10;
  localparam int unsigned LANE_W_DEF = 3;
  localparam int unsigned TERO_W_DEF = 12;
  localparam int unsigned CH_W_DEF   = 8;

  // Number of unordered group pairs that fit in the challenge encoding.
  function automatic int unsigned n_pairs(input int unsigned grp_w);
    return ((32'd1 << grp_w) / 2) * ((32'd1 << grp_w) - 1);
  endfunction

endpackage

// File: rtl/tero_pair_decode.sv
// Combinational challenge -> TERO group pair (i,j) decoder with range check.
module tero_pair_decode
  import tero_seq_pkg::*;
#(
  parameter int unsigned GRP_W = GRP_W_DEF,
  parameter int unsigned CH_W  = 2 * GRP_W
) (
  input  logic [CH_W-1:0]  ch,
  output logic [GRP_W-1:0] grp_i,
  output logic [GRP_W-1:0] grp_j,
  output logic             valid
);

  logic [GRP_W-1:0] a, b, c;
  logic [GRP_W:0]   d;

  always_comb begin
    a = ch[CH_W-1:GRP_W];
    b = ch[GRP_W-1:0];
    c = a + GRP_W'(1);
    d = {1'b0, b} + {1'b0, c};
    // A carry folds the triangle index back onto the complementary row.
    if (d[GRP_W]) begin
      grp_i = ~c;
      grp_j = b;
    end else begin
      grp_i = a;
      grp_j = d[GRP_W-1:0];
    end
    valid = (32'(ch) < n_pairs(GRP_W));
  end

endmodule

// File: rtl/tero_pair_seq.sv
// Streams every TERO index of a decoded group pair over valid/ready.
// Optional `TERO_SEQ_TAG_EN adds side/bank/lane tag outputs.
module tero_pair_seq
  import tero_seq_pkg::*;
#(
  parameter int unsigned GRP_W  = GRP_W_DEF,
  parameter int unsigned N_BANK = N_BANK_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned TERO_W = TERO_W_DEF,
  parameter int unsigned CH_W   = CH_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   challenge_in,
  output logic [TERO_W-1:0] tero_idx,
  output logic              tero_valid,
  input  logic              tero_ready,
  output logic              tero_last,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef TERO_SEQ_TAG_EN
  ,
  output logic                                        tag_side,
  output logic [((N_BANK > 1) ? $clog2(N_BANK) : 1)-1:0] tag_bank,
  output logic [LANE_W-1:0]                           tag_lane
`endif
);

  localparam int unsigned N_GRP       = 32'd1 << GRP_W;
  localparam int unsigned BANK_W      = (N_BANK > 1) ? $clog2(N_BANK) : 1;
  localparam int unsigned BANK_STRIDE = N_GRP << LANE_W;

  state_t              state_q, state_d;
  logic                side_q, side_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [GRP_W-1:0]    gi_q, gi_d, gj_q, gj_d;
  logic [TERO_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [GRP_W-1:0]    dec_i, dec_j;
  logic                dec_valid;

  tero_pair_decode #(
    .GRP_W(GRP_W),
    .CH_W (CH_W)
  ) u_decode (
    .ch   (challenge_in),
    .grp_i(dec_i),
    .grp_j(dec_j),
    .valid(dec_valid)
  );

  function automatic logic [TERO_W-1:0] tero_index(input logic [GRP_W-1:0]  g,
                                                   input logic [BANK_W-1:0] k,
                                                   input logic [LANE_W-1:0] l);
    return (TERO_W'(g) << LANE_W) + TERO_W'(k) * TERO_W'(BANK_STRIDE) + TERO_W'(l);
  endfunction

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    lane_d  = lane_q;
    bank_d  = bank_q;
    gi_d    = gi_q;
    gj_d    = gj_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (valid_q && tero_ready) begin
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            // Bank is the fastest counter, then lane, then side.
            if (bank_q == BANK_W'(N_BANK - 1)) begin
              bank_d = '0;
              if (lane_q == '1) begin
                lane_d = '0;
                side_d = 1'b1;
              end else begin
                lane_d = lane_q + LANE_W'(1);
              end
            end else begin
              bank_d = bank_q + BANK_W'(1);
            end
            idx_d  = tero_index(side_d ? gj_q : gi_q, bank_d, lane_d);
            last_d = side_d && (lane_d == '1) && (bank_d == BANK_W'(N_BANK - 1));
          end
        end
      end
      default: begin
        if (start) begin
          gi_d   = dec_i;
          gj_d   = dec_j;
          side_d = 1'b0;
          lane_d = '0;
          bank_d = '0;
          last_d = 1'b0;
          if (dec_valid) begin
            state_d = RUN;
            valid_d = 1'b1;
            idx_d   = tero_index(dec_i, '0, '0);
          end else begin
            state_d = ERR;
            valid_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      side_q  <= 1'b0;
      lane_q  <= '0;
      bank_q  <= '0;
      gi_q    <= '0;
      gj_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      lane_q  <= lane_d;
      bank_q  <= bank_d;
      gi_q    <= gi_d;
      gj_q    <= gj_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign tero_idx   = idx_q;
  assign tero_valid = valid_q;
  assign tero_last  = last_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERR);

`ifdef TERO_SEQ_TAG_EN
  // The counters always describe the beat currently held in tero_idx.
  assign tag_side = side_q;
  assign tag_bank = bank_q;
  assign tag_lane = lane_q;
`endif

endmodule
